// File: rtl/ped_phase_sequencer.sv
// ped_phase_sequencer: seconds prescaler plus CLEAR/GREEN/NIGHT rotation driving the four crossing walk phases.
module ped_phase_sequencer #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_TIME  = 20,
    parameter int ALLRED_TIME = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       night_req,
    output logic [1:0] signal_Pos,
    output logic [4:0] Count_out,
    output logic       signal,
    output logic       light_out_time,
    output logic       phase_done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(ALLRED_TIME) + 1;
    localparam logic [CW-1:0] CLR_LOAD = CW'(ALLRED_TIME - 1);
    typedef enum logic [1:0] {CLEAR, GREEN, NIGHT} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] clr_q, clr_d;
    logic [1:0]    pos_q, pos_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          night_q, night_d, done_q, done_d;
    logic          tick, half;
    assign tick = pre_q == PW'(TICK_DIV - 1);
    assign half = pre_q < PW'(TICK_DIV / 2);
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        state_d = state_q;
        clr_d   = clr_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        night_d = night_q;
        done_d  = 1'b0;
        if (tick) begin
            case (state_q)
                CLEAR: begin
                    if (clr_q != '0) begin
                        clr_d = clr_q - 1'b1;
                    end else if (night_req) begin
                        state_d = NIGHT;
                        night_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = GREEN;
                        pos_d   = pos_q + 1'b1;
                        cnt_d   = 5'(GREEN_TIME - 1);
                    end
                end
                GREEN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = CLEAR;
                        clr_d   = CLR_LOAD;
                        done_d  = 1'b1;
                    end
                end
                NIGHT: begin
                    // leaving night restarts the rotation at crossing 0
                    if (!night_req) begin
                        state_d = CLEAR;
                        clr_d   = CLR_LOAD;
                        pos_d   = 2'd3;
                        night_d = 1'b0;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            pre_q   <= '0;
            clr_q   <= CLR_LOAD;
            pos_q   <= 2'd3;
            cnt_q   <= '0;
            night_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            clr_q   <= clr_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            night_q <= night_d;
            done_q  <= done_d;
        end
    end
    assign signal         = (state_q != CLEAR) && half;
    assign signal_Pos     = pos_q;
    assign Count_out      = cnt_q;
    assign light_out_time = night_q;
    assign phase_done     = done_q;
endmodule
